// File: rtl/cache_port_arbiter.sv
// Two-port round-robin arbiter sharing one cache controller between CPU-side requesters.
// Holds controller request/address/data registered and stable for the whole transaction.
module cache_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 64,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              p0_read,
   input  logic              p0_write,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic [DATA_W-1:0] p0_rdata,
   output logic              p0_done,
   input  logic              p1_read,
   input  logic              p1_write,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic [DATA_W-1:0] p1_rdata,
   output logic              p1_done,
   output logic              read_req,
   output logic              write_req,
   output logic [ADDR_W-1:0] cpu_address,
   output logic [DATA_W-1:0] cpu_write_data,
   input  logic              done,
   input  logic [DATA_W-1:0] cpu_read_data,
   output logic              grant,
   output logic              busy,
   output logic              timeout_err,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   // Handshake: a port holds read/write level until its one-cycle pN_done, then drops it
   // during that done cycle; the controller sees requests until its done strobe.
   state_t              state_q, state_d;
   logic                last_grant_q, last_grant_d;
   logic                grant_q, grant_d;
   logic                busy_q, busy_d;
   logic                read_req_q, read_req_d;
   logic                write_req_q, write_req_d;
   logic [ADDR_W-1:0]   cpu_address_q, cpu_address_d;
   logic [DATA_W-1:0]   cpu_write_data_q, cpu_write_data_d;
   logic [DATA_W-1:0]   p0_rdata_q, p0_rdata_d;
   logic [DATA_W-1:0]   p1_rdata_q, p1_rdata_d;
   logic                p0_done_q, p0_done_d;
   logic                p1_done_q, p1_done_d;
   logic [7:0]          cnt_q, cnt_d;
   logic                timeout_err_q, timeout_err_d;

   logic p0_req, p1_req, pick;

   assign p0_req = p0_read | p0_write;
   assign p1_req = p1_read | p1_write;

   always_comb begin
      state_d          = state_q;
      last_grant_d     = last_grant_q;
      grant_d          = grant_q;
      busy_d           = busy_q;
      read_req_d       = read_req_q;
      write_req_d      = write_req_q;
      cpu_address_d    = cpu_address_q;
      cpu_write_data_d = cpu_write_data_q;
      p0_rdata_d       = p0_rdata_q;
      p1_rdata_d       = p1_rdata_q;
      p0_done_d        = p0_done_q;
      p1_done_d        = p1_done_q;
      cnt_d            = cnt_q;
      timeout_err_d    = timeout_err_q;
      pick             = 1'b0;

      case (state_q)
         IDLE: begin
            if (p0_req || p1_req) begin
               // On a tie the port that did not win last time goes next.
               pick         = (p0_req && p1_req) ? ~last_grant_q : p1_req;
               grant_d      = pick;
               last_grant_d = pick;
               busy_d       = 1'b1;
               cnt_d        = 8'd0;
               state_d      = BUSY;
               if (pick) begin
                  read_req_d       = p1_read & ~p1_write;
                  write_req_d      = p1_write;
                  cpu_address_d    = p1_addr;
                  cpu_write_data_d = p1_wdata;
               end else begin
                  read_req_d       = p0_read & ~p0_write;
                  write_req_d      = p0_write;
                  cpu_address_d    = p0_addr;
                  cpu_write_data_d = p0_wdata;
               end
            end
         end

         BUSY: begin
            if (done) begin
               if (read_req_q) begin
                  if (grant_q) p1_rdata_d = cpu_read_data;
                  else         p0_rdata_d = cpu_read_data;
               end
               read_req_d  = 1'b0;
               write_req_d = 1'b0;
               p0_done_d   = ~grant_q;
               p1_done_d   = grant_q;
               state_d     = RESP;
            end else begin
               if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
               if (cnt_d >= TIMEOUT_C) timeout_err_d = 1'b1;
            end
         end

         RESP: begin
            p0_done_d = 1'b0;
            p1_done_d = 1'b0;
            busy_d    = 1'b0;
            state_d   = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= IDLE;
         last_grant_q     <= 1'b1;
         grant_q          <= 1'b0;
         busy_q           <= 1'b0;
         read_req_q       <= 1'b0;
         write_req_q      <= 1'b0;
         cpu_address_q    <= '0;
         cpu_write_data_q <= '0;
         p0_rdata_q       <= '0;
         p1_rdata_q       <= '0;
         p0_done_q        <= 1'b0;
         p1_done_q        <= 1'b0;
         cnt_q            <= 8'd0;
         timeout_err_q    <= 1'b0;
      end else begin
         state_q          <= state_d;
         last_grant_q     <= last_grant_d;
         grant_q          <= grant_d;
         busy_q           <= busy_d;
         read_req_q       <= read_req_d;
         write_req_q      <= write_req_d;
         cpu_address_q    <= cpu_address_d;
         cpu_write_data_q <= cpu_write_data_d;
         p0_rdata_q       <= p0_rdata_d;
         p1_rdata_q       <= p1_rdata_d;
         p0_done_q        <= p0_done_d;
         p1_done_q        <= p1_done_d;
         cnt_q            <= cnt_d;
         timeout_err_q    <= timeout_err_d;
      end
   end

   assign p0_rdata       = p0_rdata_q;
   assign p1_rdata       = p1_rdata_q;
   assign p0_done        = p0_done_q;
   assign p1_done        = p1_done_q;
   assign read_req       = read_req_q;
   assign write_req      = write_req_q;
   assign cpu_address    = cpu_address_q;
   assign cpu_write_data = cpu_write_data_q;
   assign grant          = grant_q;
   assign busy           = busy_q;
   assign timeout_err    = timeout_err_q;
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter: vector table plus hand sequences for
// reset, contention, mid-transaction reset and controller timeout.
module tb_cache_port_arbiter;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 64;

   logic              clk;
   logic              rst_n;
   logic              p0_read, p0_write, p1_read, p1_write;
   logic [ADDR_W-1:0] p0_addr, p1_addr;
   logic [DATA_W-1:0] p0_wdata, p1_wdata;
   logic [DATA_W-1:0] p0_rdata, p1_rdata;
   logic              p0_done, p1_done;
   logic              read_req, write_req;
   logic [ADDR_W-1:0] cpu_address;
   logic [DATA_W-1:0] cpu_write_data;
   logic              done;
   logic [DATA_W-1:0] cpu_read_data;
   logic              grant, busy, timeout_err;
   logic [1:0]        dbg_state;

   int n_pass;
   int n_total;

   cache_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .p0_read(p0_read), .p0_write(p0_write), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_rdata(p0_rdata), .p0_done(p0_done),
      .p1_read(p1_read), .p1_write(p1_write), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_rdata(p1_rdata), .p1_done(p1_done),
      .read_req(read_req), .write_req(write_req), .cpu_address(cpu_address),
      .cpu_write_data(cpu_write_data), .done(done), .cpu_read_data(cpu_read_data),
      .grant(grant), .busy(busy), .timeout_err(timeout_err), .dbg_state(dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        p0r, p0w, p1r, p1w, dn;
      logic [63:0] crd;
      logic        e_rreq, e_wreq, e_busy, e_grant, e_p0d, e_p1d;
      logic [31:0] e_addr;
      logic [63:0] e_wdata, e_p0rd, e_p1rd;
   } vec_t;

   vec_t vecs[15];

   localparam logic [31:0] A0 = 32'h0000_1000;
   localparam logic [31:0] A1 = 32'h0000_2000;
   localparam logic [63:0] W0 = 64'h0000_0000_0000_A0A0;
   localparam logic [63:0] W1 = 64'h0000_0000_0000_0055;
   localparam logic [63:0] DB = 64'hDEAD_BEEF_0123_4567;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else n_pass++;
   endtask

   logic        exp_q[$];
   logic        eg;
   logic [63:0] exp_wd;
   int          waited;

   initial begin
      n_pass = 0;
      n_total = 0;
      rst_n = 1'b0;
      p0_read = 1'b1; p0_write = 1'b1; p1_read = 1'b0; p1_write = 1'b1;
      p0_addr = A0; p1_addr = A1;
      p0_wdata = 64'hA000_0000; p1_wdata = 64'hB000_0000;
      done = 1'b0; cpu_read_data = '0;

      // Reset held with requests active
      repeat (3) step();
      chk("rst ctl", 64'({read_req, write_req, busy, grant, p0_done, p1_done, timeout_err}), 64'd0);
      chk("rst addr", 64'(cpu_address), 64'd0);
      chk("rst wdata", cpu_write_data, 64'd0);
      chk("rst p0_rdata", p0_rdata, 64'd0);
      chk("rst p1_rdata", p1_rdata, 64'd0);
      chk("rst state", 64'(dbg_state), 64'd0);

      // Contention: both ports write continuously, grants must alternate from port 0
      p0_read = 1'b0;
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) exp_q.push_back(k[0]);
      for (int k = 0; k < 6; k++) begin
         waited = 0;
         while (write_req !== 1'b1 && waited < 10) begin
            step();
            waited++;
         end
         chk($sformatf("cont%0d write_req", k), 64'(write_req), 64'd1);
         eg = exp_q.pop_front();
         exp_wd = eg ? p1_wdata : p0_wdata;
         chk($sformatf("cont%0d grant", k), 64'(grant), 64'(eg));
         chk($sformatf("cont%0d wdata", k), cpu_write_data, exp_wd);
         chk($sformatf("cont%0d addr", k), 64'(cpu_address), 64'(eg ? A1 : A0));
         chk($sformatf("cont%0d read_req", k), 64'(read_req), 64'd0);
         p0_wdata = p0_wdata + 64'd1;
         p1_wdata = p1_wdata + 64'd1;
         step();
         chk($sformatf("cont%0d wdata stable", k), cpu_write_data, exp_wd);
         done = 1'b1;
         step();
         done = 1'b0;
         chk($sformatf("cont%0d pdone", k), 64'({p0_done, p1_done}), eg ? 64'd1 : 64'd2);
         chk($sformatf("cont%0d req low", k), 64'({read_req, write_req}), 64'd0);
      end
      p0_write = 1'b0; p1_write = 1'b0;
      p0_wdata = W0; p1_wdata = W1;
      step();
      step();

      // Reset two cycles after a grant: requests drop asynchronously, no pN_done
      p0_read = 1'b1;
      step();
      chk("mid rst granted", 64'(read_req), 64'd1);
      step();
      step();
      #2 rst_n = 1'b0;
      #1;
      chk("mid rst async", 64'({read_req, write_req, busy}), 64'd0);
      p0_read = 1'b0;
      step();
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         chk($sformatf("mid rst no done %0d", c), 64'({p0_done, p1_done, busy}), 64'd0);
      end

      // Vector table: inputs for one cycle, outputs expected after the following edge
      vecs[0]  = '{1,0,0,0,0, 64'h0,         1,0,1,0,0,0, A0, W0, 64'h0,    64'h0};
      vecs[1]  = '{1,0,0,0,0, 64'h0,         1,0,1,0,0,0, A0, W0, 64'h0,    64'h0};
      vecs[2]  = '{1,0,0,0,0, 64'h0,         1,0,1,0,0,0, A0, W0, 64'h0,    64'h0};
      vecs[3]  = '{1,0,0,0,1, DB,            0,0,1,0,1,0, A0, W0, DB,       64'h0};
      vecs[4]  = '{0,0,0,0,0, 64'h0,         0,0,0,0,0,0, A0, W0, DB,       64'h0};
      vecs[5]  = '{0,0,0,0,1, 64'hBAD,       0,0,0,0,0,0, A0, W0, DB,       64'h0};
      vecs[6]  = '{0,0,1,1,0, 64'h0,         0,1,1,1,0,0, A1, W1, DB,       64'h0};
      vecs[7]  = '{0,0,1,1,1, 64'hCAFE,      0,0,1,1,0,1, A1, W1, DB,       64'h0};
      vecs[8]  = '{0,0,0,0,0, 64'h0,         0,0,0,0,0,0, A1, W1, DB,       64'h0};
      vecs[9]  = '{1,0,1,0,0, 64'h0,         1,0,1,0,0,0, A0, W0, DB,       64'h0};
      vecs[10] = '{1,0,1,0,1, 64'h1111,      0,0,1,0,1,0, A0, W0, 64'h1111, 64'h0};
      vecs[11] = '{0,0,1,0,0, 64'h0,         0,0,0,0,0,0, A0, W0, 64'h1111, 64'h0};
      vecs[12] = '{0,0,1,0,0, 64'h0,         1,0,1,1,0,0, A1, W1, 64'h1111, 64'h0};
      vecs[13] = '{0,0,1,0,1, 64'h2222,      0,0,1,1,0,1, A1, W1, 64'h1111, 64'h2222};
      vecs[14] = '{0,0,0,0,0, 64'h0,         0,0,0,0,0,0, A1, W1, 64'h1111, 64'h2222};

      for (int i = 0; i < 15; i++) begin
         p0_read = vecs[i].p0r; p0_write = vecs[i].p0w;
         p1_read = vecs[i].p1r; p1_write = vecs[i].p1w;
         done = vecs[i].dn; cpu_read_data = vecs[i].crd;
         step();
         done = 1'b0;
         chk($sformatf("v%0d ctl", i), 64'({read_req, write_req, busy, p0_done, p1_done}),
             64'({vecs[i].e_rreq, vecs[i].e_wreq, vecs[i].e_busy, vecs[i].e_p0d, vecs[i].e_p1d}));
         if (vecs[i].e_busy) begin
            chk($sformatf("v%0d grant", i), 64'(grant), 64'(vecs[i].e_grant));
            chk($sformatf("v%0d addr", i), 64'(cpu_address), 64'(vecs[i].e_addr));
            chk($sformatf("v%0d wdata", i), cpu_write_data, vecs[i].e_wdata);
         end
         chk($sformatf("v%0d p0_rdata", i), p0_rdata, vecs[i].e_p0rd);
         chk($sformatf("v%0d p1_rdata", i), p1_rdata, vecs[i].e_p1rd);
      end

      // Timeout: TIMEOUT=8, controller withholds done
      p0_write = 1'b1;
      step();
      chk("to granted", 64'(write_req), 64'd1);
      repeat (7) step();
      chk("to not yet", 64'(timeout_err), 64'd0);
      step();
      chk("to set", 64'(timeout_err), 64'd1);
      repeat (4) step();
      chk("to sticky busy", 64'({timeout_err, write_req, busy}), 64'h7);
      done = 1'b1;
      step();
      done = 1'b0;
      chk("to late done", 64'({p0_done, p1_done, timeout_err}), 64'h5);
      p0_write = 1'b0;
      step();
      chk("to idle sticky", 64'({busy, timeout_err}), 64'h1);
      rst_n = 1'b0;
      #1;
      chk("to reset clears", 64'(timeout_err), 64'd0);
      rst_n = 1'b1;
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
